// File: rtl/serial_cmd_decoder_if.sv
// Signal bundle between the serial command decoder and its surroundings:
// UART receive/transmit byte streams plus the write/read bus request side.
interface serial_cmd_decoder_if #(
  parameter int ADDR_DIGITS = 6
);
  localparam int AW = 4 * ADDR_DIGITS;

  logic [7:0]    rx_data;
  logic          rx_strobe;
  logic [7:0]    tx_data;
  logic          tx_strobe;
  logic          tx_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_strobe;
  logic [AW-1:0] rd_addr;
  logic          rd_strobe;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          overrun;

  // Decoder side: consumes rx bytes and read results, issues replies and bus requests.
  modport master (
    input  rx_data, rx_strobe, tx_ready, rd_data, rd_valid,
    output tx_data, tx_strobe, wr_addr, wr_data, wr_strobe, rd_addr, rd_strobe, overrun
  );

  // Environment side: UART pair and memory/register bus.
  modport slave (
    output rx_data, rx_strobe, tx_ready, rd_data, rd_valid,
    input  tx_data, tx_strobe, wr_addr, wr_data, wr_strobe, rd_addr, rd_strobe, overrun
  );
endinterface

// File: rtl/serial_cmd_decoder.sv
// Parses ASCII hex command lines ("W<addr><dd>\n", "R<addr>\n") from uart_rx into
// bus write/read requests and encodes short ASCII replies ("K\n", "<hh>\n", "?\n") for uart_tx.
module serial_cmd_decoder #(
  parameter int ADDR_DIGITS = 6,
  parameter int TIMEOUT     = 12000000
) (
  input  logic                  mclk,
  input  logic                  reset,
  serial_cmd_decoder_if.master  bus
);

  localparam int AW = 4 * ADDR_DIGITS;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(ADDR_DIGITS + 1);

  localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);
  localparam logic [DW-1:0] ADDR_LAST = DW'(ADDR_DIGITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_EOL     = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WAIT_RD = 3'd5;
  localparam logic [2:0] S_SKIP    = 3'd6;
  localparam logic [2:0] S_REPLY   = 3'd7;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_Q  = 8'h3F;

  // {valid, nibble} for one ASCII hex character
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  logic [2:0]    state;
  logic          is_write;
  logic [AW-1:0] addr_sr;
  logic [7:0]    data_sr;
  logic [DW-1:0] digit_cnt;
  logic [CW-1:0] tmo_cnt;
  logic          wr_strobe_q;
  logic          rd_strobe_q;
  logic [AW-1:0] wr_addr_q;
  logic [7:0]    wr_data_q;
  logic [AW-1:0] rd_addr_q;
  logic [23:0]   reply_sr;
  logic [1:0]    reply_left;
  logic          tx_gap;

  logic [4:0] hex;
  logic       hex_ok;
  logic [3:0] nib;
  logic       is_cr, is_lf, is_sp, is_w, is_r;
  logic       busy, rx_take, timed_state, syntax_err, tx_fire;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hex         = hex_decode(bus.rx_data);
    hex_ok      = hex[4];
    nib         = hex[3:0];
    is_cr       = (bus.rx_data == CH_CR);
    is_lf       = (bus.rx_data == CH_LF);
    is_sp       = (bus.rx_data == CH_SP);
    is_w        = (bus.rx_data == CH_W);
    is_r        = (bus.rx_data == CH_R);
    busy        = (state == S_EXEC) || (state == S_WAIT_RD) || (state == S_REPLY);
    rx_take     = bus.rx_strobe && !busy;
    timed_state = (state == S_ADDR) || (state == S_DATA) || (state == S_EOL) || (state == S_SKIP);
    tx_fire     = (state == S_REPLY) && !tx_gap && bus.tx_ready;
    syntax_err  = 1'b0;
    if (rx_take && !is_cr) begin
      case (state)
        S_IDLE:         syntax_err = !(is_lf || is_sp || is_w || is_r);
        S_ADDR, S_DATA: syntax_err = !hex_ok;
        S_EOL:          syntax_err = !is_lf;
        default:        syntax_err = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      addr_sr     <= '0;
      data_sr     <= '0;
      digit_cnt   <= '0;
      tmo_cnt     <= '0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      reply_sr    <= '0;
      reply_left  <= '0;
      tx_gap      <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      tx_gap      <= 1'b0;

      // Inter-byte watchdog: cleared by each accepted byte, saturates at TIMEOUT.
      if (rx_take || !timed_state)  tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)  tmo_cnt <= tmo_cnt + 1'b1;

      if (syntax_err) begin
        // A bad '\n' already ends the line, so reply at once instead of skipping to the next one.
        if (is_lf) begin
          reply_sr   <= {CH_Q, CH_LF, 8'h00};
          reply_left <= 2'd2;
          state      <= S_REPLY;
        end else begin
          state <= S_SKIP;
        end
      end else if (timed_state && !rx_take && tmo_cnt == TMO_MAX) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (rx_take && (is_w || is_r)) begin
              is_write  <= is_w;
              addr_sr   <= '0;
              data_sr   <= '0;
              digit_cnt <= '0;
              state     <= S_ADDR;
            end
          end

          S_ADDR: begin
            if (rx_take && hex_ok) begin
              addr_sr <= {addr_sr[AW-5:0], nib};
              if (digit_cnt == ADDR_LAST) begin
                digit_cnt <= '0;
                state     <= is_write ? S_DATA : S_EOL;
              end else begin
                digit_cnt <= digit_cnt + 1'b1;
              end
            end
          end

          S_DATA: begin
            if (rx_take && hex_ok) begin
              data_sr <= {data_sr[3:0], nib};
              if (digit_cnt == DW'(1)) begin
                digit_cnt <= '0;
                state     <= S_EOL;
              end else begin
                digit_cnt <= digit_cnt + 1'b1;
              end
            end
          end

          S_EOL: begin
            if (rx_take && is_lf) begin
              if (is_write) begin
                wr_strobe_q <= 1'b1;
                wr_addr_q   <= addr_sr;
                wr_data_q   <= data_sr;
              end else begin
                rd_strobe_q <= 1'b1;
                rd_addr_q   <= addr_sr;
              end
              state <= S_EXEC;
            end
          end

          S_EXEC: begin
            if (is_write) begin
              reply_sr   <= {CH_K, CH_LF, 8'h00};
              reply_left <= 2'd2;
              state      <= S_REPLY;
            end else begin
              state <= S_WAIT_RD;
            end
          end

          S_WAIT_RD: begin
            if (bus.rd_valid) begin
              reply_sr   <= {hex_char(bus.rd_data[7:4]), hex_char(bus.rd_data[3:0]), CH_LF};
              reply_left <= 2'd3;
              state      <= S_REPLY;
            end
          end

          S_SKIP: begin
            if (rx_take && is_lf) begin
              reply_sr   <= {CH_Q, CH_LF, 8'h00};
              reply_left <= 2'd2;
              state      <= S_REPLY;
            end
          end

          S_REPLY: begin
            // One idle cycle after each byte lets the transmitter drop tx_ready before we look again.
            if (tx_fire) begin
              reply_sr   <= {reply_sr[15:0], 8'h00};
              reply_left <= reply_left - 1'b1;
              tx_gap     <= 1'b1;
              if (reply_left == 2'd1) state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_strobe = tx_fire;
  assign bus.tx_data   = (state == S_REPLY) ? reply_sr[23:16] : 8'h00;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.overrun   = bus.rx_strobe && busy;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Directed bench for serial_cmd_decoder: expected replies and bus requests are queued
// as commands are sent and compared as the decoder produces them.
module tb_serial_cmd_decoder;

  localparam int ADDR_DIGITS = 6;
  localparam int TIMEOUT     = 100;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic mclk  = 1'b0;
  logic reset = 1'b0;

  serial_cmd_decoder_if #(.ADDR_DIGITS(ADDR_DIGITS)) dut_if ();

  serial_cmd_decoder #(.ADDR_DIGITS(ADDR_DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (dut_if.master)
  );

  always #5 mclk = ~mclk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rx_cyc = -10;
  int          rd_cyc = 0;
  int          tx_cnt = 0;
  int          ovr_cnt = 0;
  int          tx_busy = 0;
  bit          tx_block = 1'b0;
  bit          rd_seen = 1'b0;
  logic [7:0]  exp_tx[$];
  wr_t         exp_wr[$];
  logic [23:0] exp_rd[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples outputs mid-cycle and matches them against the scoreboard.
  task automatic monitor();
    logic [7:0]  b;
    logic [23:0] a;
    wr_t         w;
    cyc++;
    if (dut_if.tx_strobe === 1'b1) begin
      check("tx_ready_at_strobe", {31'd0, dut_if.tx_ready}, 1);
      check("tx_expected", {31'd0, exp_tx.size() != 0}, 1);
      if (exp_tx.size() != 0) begin
        b = exp_tx.pop_front();
        check("tx_data", {24'd0, dut_if.tx_data}, {24'd0, b});
      end
      tx_cnt++;
      tx_busy = 3;
    end
    if (dut_if.wr_strobe === 1'b1) begin
      check("wr_latency", cyc - last_rx_cyc, 1);
      check("wr_expected", {31'd0, exp_wr.size() != 0}, 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", {8'd0, dut_if.wr_addr}, {8'd0, w.addr});
        check("wr_data", {24'd0, dut_if.wr_data}, {24'd0, w.data});
      end
    end
    if (dut_if.rd_strobe === 1'b1) begin
      check("rd_latency", cyc - last_rx_cyc, 1);
      check("rd_expected", {31'd0, exp_rd.size() != 0}, 1);
      if (exp_rd.size() != 0) begin
        a = exp_rd.pop_front();
        check("rd_addr", {8'd0, dut_if.rd_addr}, {8'd0, a});
      end
      rd_seen = 1'b1;
      rd_cyc  = cyc;
    end
    if (dut_if.overrun === 1'b1) ovr_cnt++;
    if (dut_if.rx_strobe === 1'b1) last_rx_cyc = cyc;
  endtask

  // Check current inputs against outputs at negedge, then let the active edge happen.
  task automatic tick();
    @(negedge mclk);
    monitor();
    @(posedge mclk);
    #1;
    if (tx_busy > 0) tx_busy--;
    dut_if.tx_ready = !tx_block && (tx_busy == 0);
  endtask

  task automatic send(input logic [7:0] b);
    dut_if.rx_data   = b;
    dut_if.rx_strobe = 1'b1;
    tick();
    dut_if.rx_strobe = 1'b0;
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic push_tx(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
  endtask

  task automatic push_wr(input logic [23:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && exp_tx.size() != 0; i++) tick();
    check(tag, exp_tx.size(), 0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic wait_rd();
    for (int i = 0; i < 50 && !rd_seen; i++) tick();
    check("rd_strobe_seen", {31'd0, rd_seen}, 1);
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    dut_if.rd_data  = d;
    dut_if.rd_valid = 1'b1;
    tick();
    dut_if.rd_valid = 1'b0;
  endtask

  initial begin
    int ovr0, tx0;
    dut_if.rx_data   = 8'h00;
    dut_if.rx_strobe = 1'b0;
    dut_if.tx_ready  = 1'b1;
    dut_if.rd_data   = 8'h00;
    dut_if.rd_valid  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_tx_strobe", {31'd0, dut_if.tx_strobe}, 0);
    check("rst_tx_data",   {24'd0, dut_if.tx_data}, 0);
    check("rst_wr_strobe", {31'd0, dut_if.wr_strobe}, 0);
    check("rst_wr_addr",   {8'd0, dut_if.wr_addr}, 0);
    check("rst_rd_strobe", {31'd0, dut_if.rd_strobe}, 0);
    check("rst_overrun",   {31'd0, dut_if.overrun}, 0);
    reset = 1'b1;
    tick();

    // Short data field: '\n' lands where a hex digit belongs
    push_tx("?\n");
    send_str("W0012AB5\n");
    drain("short_write_reply");
    push_wr(24'h0012AB, 8'hC5);
    push_tx("K\n");
    send_str("W0012ABc5\n");
    drain("write_reply");

    // Read with 5-cycle bus latency, '\r' before '\n'
    rd_seen = 1'b0;
    exp_rd.push_back(24'h00FFFF);
    send_str("R00FFFF\r\n");
    wait_rd();
    while (cyc < rd_cyc + 4) tick();
    push_tx("3E\n");
    pulse_rd(8'h3E);
    check("rd_valid_5_cycles", cyc - rd_cyc, 5);
    drain("read_reply");

    // Bad command letter, bad address digit, then a good command
    push_tx("?\n");
    send_str("X\n");
    drain("bad_cmd_reply");
    push_tx("?\n");
    send_str("Rzz\n");
    drain("bad_addr_reply");
    push_wr(24'h00000A, 8'h11);
    push_tx("K\n");
    send_str(" W00000A11\n");
    drain("recover_write_reply");

    // Inter-byte timeout aborts silently
    send_str("W12");
    for (int i = 0; i < TIMEOUT + 50; i++) tick();
    check("timeout_no_tx", exp_tx.size(), 0);
    push_wr(24'h000001, 8'hFF);
    push_tx("K\n");
    send_str("W000001FF\n");
    drain("post_timeout_reply");

    // Reply stalled by tx_ready=0 while bytes arrive; rx and rd_valid collide
    rd_seen = 1'b0;
    exp_rd.push_back(24'h000010);
    send_str("R000010\n");
    wait_rd();
    tick();
    ovr0 = ovr_cnt;
    tx_block = 1'b1;
    dut_if.tx_ready = 1'b0;
    push_tx("A7\n");
    dut_if.rx_data   = 8'h57;
    dut_if.rx_strobe = 1'b1;
    pulse_rd(8'hA7);
    dut_if.rx_strobe = 1'b0;
    tx0 = tx_cnt;
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 20) begin
        dut_if.rx_data   = 8'h52;
        dut_if.rx_strobe = 1'b1;
      end
      tick();
      dut_if.rx_strobe = 1'b0;
    end
    check("stall_no_tx", tx_cnt - tx0, 0);
    check("stall_overruns", ovr_cnt - ovr0, 3);
    tx_block = 1'b0;
    drain("stall_reply");
    check("stall_reply_bytes", tx_cnt - tx0, 3);

    // Asynchronous reset while waiting for read data
    rd_seen = 1'b0;
    exp_rd.push_back(24'h000020);
    send_str("R000020\n");
    wait_rd();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("areset_rd_addr",   {8'd0, dut_if.rd_addr}, 0);
    check("areset_wr_addr",   {8'd0, dut_if.wr_addr}, 0);
    check("areset_wr_data",   {24'd0, dut_if.wr_data}, 0);
    check("areset_tx_strobe", {31'd0, dut_if.tx_strobe}, 0);
    check("areset_rd_strobe", {31'd0, dut_if.rd_strobe}, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    pulse_rd(8'h55);
    for (int i = 0; i < 20; i++) tick();
    check("stale_rd_valid_no_tx", exp_tx.size(), 0);
    push_wr(24'h00ABCD, 8'h12);
    push_tx("K\n");
    send_str("W00ABCD12\n");
    drain("post_reset_reply");

    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("total_overruns", ovr_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_cmd_decoder.md
Name: serial_cmd_decoder

Overview:
- Host-facing command endpoint on the receive side of the serial link.
- Consumes bytes delivered by uart_rx (data + one-cycle strobe) and parses ASCII hex command lines into write/read bus requests.
- Encodes a short ASCII reply for the host as bytes for uart_tx.
- Sits between the UART pair and the memory/register side of the design; replaces plain echo as the host protocol.

Parameters:
ADDR_DIGITS, 6, number of hex address digits per command; address width = 4*ADDR_DIGITS
TIMEOUT, 12000000, mclk cycles allowed between bytes of one command before abort (100 ms at 120 MHz)

Ports:
mclk  input  1  system clock; all logic on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
rx_data  input  8  received byte
rx_strobe  input  1  one-cycle pulse; rx_data valid
tx_data  output  8  reply byte
tx_strobe  output  1  one-cycle pulse; tx_data valid
tx_ready  input  1  transmitter idle and able to accept a byte
wr_addr  output  4*ADDR_DIGITS  write address
wr_data  output  8  write data
wr_strobe  output  1  one-cycle write request
rd_addr  output  4*ADDR_DIGITS  read address
rd_strobe  output  1  one-cycle read request
rd_data  input  8  read result
rd_valid  input  1  one-cycle pulse; rd_data valid, any latency >= 1 cycle
overrun  output  1  one-cycle pulse; rx byte dropped while busy

Behaviour:
- Reset (async, reset=0): all outputs 0; addr/data shift registers 0; state IDLE; timeout counter 0.
- Grammar: 'W' + ADDR_DIGITS hex + 2 hex + '\n' → write. 'R' + ADDR_DIGITS hex + '\n' → read. Hex digits: 0-9, A-F, a-f. '\r' is ignored in every receive state. In IDLE, '\n' and ' ' are ignored.
- Digits shift in MSB first: reg <= {reg[W-5:0], nibble}.
- States:
  - IDLE: 'W'/'R' → ADDR; clears addr and digit counter. Any other byte → SKIP with err flag.
  - ADDR: hex → shift, count++. After ADDR_DIGITS digits → DATA (W) or EOL (R). Non-hex → SKIP.
  - DATA: two hex digits → EOL. Non-hex → SKIP.
  - EOL: '\n' → EXEC. Any other byte → SKIP.
  - EXEC: W asserts wr_strobe for one cycle with wr_addr/wr_data, then replies "K\n". R asserts rd_strobe for one cycle with rd_addr, then WAIT_RD.
  - WAIT_RD: on rd_valid, latch rd_data, reply two uppercase hex chars + '\n'. No timeout in WAIT_RD.
  - SKIP: discard bytes until '\n', then reply "?\n"; → IDLE.
- Latency:
  - wr_strobe is asserted the cycle after the '\n' strobe.
  - rd_strobe is asserted the cycle after the '\n' strobe.
- Reply engine:
  - tx_strobe is asserted only in a cycle where tx_ready=1.
  - tx_data is held stable that cycle.
  - After each strobe, wait at least one cycle for tx_ready to be seen high again before the next byte.
  - → IDLE after the last byte strobes.
- Busy handling: rx_strobe during EXEC, WAIT_RD or reply: byte dropped, overrun pulses the same cycle, state unchanged.
- Timeout:
  - Counter resets on every accepted rx_strobe; counts only in ADDR/DATA/EOL/SKIP.
  - Reaching TIMEOUT → IDLE silently with no reply.
  - Counter saturates; no wrap.
- Simultaneous rx_strobe and rd_valid in WAIT_RD: rd_valid is processed; the byte is dropped with overrun.
- Reset asserted mid-command or mid-reply: immediate return to IDLE; any in-flight strobe is deasserted.

Test Plan:
- Send "W0012AB5\n": the cycle after '\n', wr_strobe=1, wr_addr=24'h0012AB, wr_data=8'h5? must NOT occur; instead SKIP → reply "?\n" (only one data digit, '\n' is non-hex). Then send "W0012ABc5\n" → wr_addr=0x0012AB, wr_data=0xC5 for exactly one cycle; tx bytes 'K','\n'.
- Send "R00FFFF\r\n" with rd_valid 5 cycles after rd_strobe and rd_data=0x3E: rd_addr=0x00FFFF; tx bytes '3','E','\n'.
- Send "X\n": no bus strobes; tx "?\n". Then "Rzz" + "\n": tx "?\n"; the decoder accepts a following valid command.
- Send "W12" then idle TIMEOUT cycles (bench TIMEOUT=100): no reply; next "W000001FF\n" → wr_strobe with wr_data=0xFF.
- Hold tx_ready=0 for 50 cycles during the read reply while injecting 2 rx bytes: no tx_strobe while tx_ready=0; overrun pulses twice; the reply completes intact once tx_ready=1.
- Pull reset low in WAIT_RD: all outputs 0 asynchronously; a later rd_valid is ignored; next command works.
